// File: rtl/piso_shift_register_pkg.sv
// Shared definitions for the parallel-in serial-out shift stage.
// Holds the FSM state encoding and the counter-width helper.
package piso_shift_register_pkg;

    // Two-state sequencer, 1-bit encoding.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Counter width: wide enough to hold n (the parity cycle index).
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit counter for the PISO stage: synchronous clear with priority over
// enable, and a terminal-count flag decoded from the registered count.
module piso_bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [CW-1:0] term_i,
    output logic [CW-1:0] count_o,
    output logic          tc_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise increment when enabled.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == term_i);

endmodule

// File: rtl/piso_shift_register.sv
// Parallel-in serial-out stage: captures an n-bit word when ready and
// shifts it out MSB first, one bit per clock, with per-bit valid and a
// done flag on the final bit.
// Optional feature: define PISO_PARITY_EN to append an even-parity bit
// (XOR of the word) as one extra serial cycle; done then marks that cycle.
module piso_shift_register
    import piso_shift_register_pkg::*;
#(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [n-1:0] I,
    output logic         ready,
    output logic         sout,
    output logic         sout_valid,
    output logic         done
);

    localparam int CW = cnt_width(n);

`ifdef PISO_PARITY_EN
    // Last serial cycle is the parity bit at index n.
    localparam logic [CW-1:0] TERM = CW'(n);
`else
    localparam logic [CW-1:0] TERM = CW'(n - 1);
`endif

    state_e        state_q;
    state_e        state_d;
    logic [n-1:0]  shift_q;
    logic [n-1:0]  shift_d;
    logic [CW-1:0] cnt_q;
    logic          cnt_tc;
    logic          cnt_clr;
    logic          cnt_en;
    logic          accept;

    assign accept  = (state_q == IDLE) && load;
    // Counter sits at zero in IDLE and clears on the final serial cycle.
    assign cnt_clr = (state_q == IDLE) || cnt_tc;
    assign cnt_en  = (state_q == SHIFT);

    piso_bit_counter #(
        .CW (CW)
    ) u_bit_counter (
        .clk     (clk),
        .rst_n   (reset_n),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .term_i  (TERM),
        .count_o (cnt_q),
        .tc_o    (cnt_tc)
    );

    // Next-state and shift-register update.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (which would infer a latch).
        state_d = state_q;
        shift_d = shift_q;
        unique case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SHIFT;
                    shift_d = I;
                end
            end
            SHIFT: begin
                shift_d = shift_q << 1;
                if (cnt_tc) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and shift-register flops with asynchronous abort.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: non-blocking assignments here so every flop samples pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
        end
    end

`ifdef PISO_PARITY_EN
    logic parity_q;

    // Even-parity bit of the word, captured on the accepting edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            parity_q <= 1'b0;
        end else if (accept) begin
            parity_q <= ^I;
        end
    end

    // Output decode; the parity bit follows the n data bits.
    always_comb begin
        ready      = (state_q == IDLE);
        sout_valid = (state_q == SHIFT);
        done       = (state_q == SHIFT) && cnt_tc;
        sout       = 1'b0;
        if (state_q == SHIFT) begin
            sout = (cnt_q == CW'(n)) ? parity_q : shift_q[n-1];
        end
    end
`else
    // Output decode from registered state only.
    always_comb begin
        ready      = (state_q == IDLE);
        sout_valid = (state_q == SHIFT);
        done       = (state_q == SHIFT) && cnt_tc;
        sout       = (state_q == SHIFT) ? shift_q[n-1] : 1'b0;
    end

    // accept is only consumed by the parity capture.
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule
